// File: rtl/sram_port_arb_if.sv
// sram_port_arb_if
// Bundles the requester-side command/response signals and the SRAM-side
// port of the shared-SRAM arbiter.
//   slave  : the arbiter view (takes commands and mem_q, drives gnt/rvalid/
//            rdata/busy and the registered SRAM command).
//   master : the environment view (requesters plus the SRAM macro).
// Handshake: a requester raises req[i] with its payload and must hold both
// stable until gnt[i]; the command is accepted at the clock edge where
// req[i] && gnt[i]. Read data returns on rdata qualified by rvalid[i].
interface sram_port_arb_if #(
    parameter int NREQ = 4,
    parameter int AW   = 16,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_we;
    logic [NREQ-1:0]    req_lock;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ*DW-1:0] req_bwe;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;
    logic               mem_ce;
    logic               mem_we;
    logic [DW-1:0]      mem_bwe;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_data;
    logic [DW-1:0]      mem_q;
    logic               busy;

    modport slave (
        input  req, req_we, req_lock, req_addr, req_wdata, req_bwe, mem_q,
        output gnt, rvalid, rdata, mem_ce, mem_we, mem_bwe, mem_addr,
               mem_data, busy
    );

    modport master (
        output req, req_we, req_lock, req_addr, req_wdata, req_bwe, mem_q,
        input  gnt, rvalid, rdata, mem_ce, mem_we, mem_bwe, mem_addr,
               mem_data, busy
    );
endinterface

// File: rtl/sram_port_arb.sv
// sram_port_arb
// Round-robin arbiter sharing one single-port SRAM between NREQ requesters.
// The winner's command is registered onto the SRAM port; read data comes
// back two cycles after the grant, steered to the issuer via rvalid.
// A requester may hold the port for up to MAX_BURST beats with req_lock.
// Ports:
//   clk          single clock
//   rst          asynchronous active-high reset
//   bus          sram_port_arb_if.slave (requester commands, SRAM port)
//   o_dbg_state  lock FSM state (0 = idle, 1 = locked)
module sram_port_arb #(
    parameter int NREQ      = 4,
    parameter int AW        = 16,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_port_arb_if.slave       bus,
    output logic [0:0]           o_dbg_state
);
    localparam int              PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW:0]     NREQ_W   = NREQ[PW:0];
    localparam logic [PW:0]     ONE_P    = {{PW{1'b0}}, 1'b1};
    localparam logic [3:0]      MAXB_W   = MAX_BURST[3:0];
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

    lock_state_e     r_state;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_owner;
    logic [3:0]      r_cnt;

    logic            r_mem_ce;
    logic            r_mem_we;
    logic [DW-1:0]   r_mem_bwe;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_data;

    // Read-return pipe: stage 0 during the SRAM access cycle, stage 1 while
    // mem_q holds the data.
    logic            r_p0_vld;
    logic [PW-1:0]   r_p0_id;
    logic            r_p1_vld;
    logic [PW-1:0]   r_p1_id;

    logic [2*NREQ-1:0] w_req_dbl;
    logic [NREQ-1:0]   w_req_rot;
    logic [PW:0]       w_rr_off;
    logic [PW-1:0]     w_rr_idx;
    logic [NREQ-1:0]   w_owner_oh;
    logic              w_owner_req;
    logic              w_others;
    logic              w_hold;
    logic [PW-1:0]     w_win;
    logic [NREQ-1:0]   w_gnt;
    logic              w_accept;
    logic              w_win_we;
    logic              w_win_lock;
    logic [AW-1:0]     w_win_addr;
    logic [DW-1:0]     w_win_data;
    logic [DW-1:0]     w_win_bwe;

    // (a + b) mod NREQ for a < NREQ and b < NREQ.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] a,
                                               input logic [PW:0]   b);
        logic [PW:0] s;
        s = {1'b0, a} + b;
        if (s >= NREQ_W) begin
            s = s - NREQ_W;
        end
        return s[PW-1:0];
    endfunction

    // Rotating the doubled request vector by ptr puts the scan start at
    // bit 0, so the lowest set bit is the round-robin offset from ptr.
    assign w_req_dbl = {bus.req, bus.req};
    assign w_req_rot = w_req_dbl[r_ptr +: NREQ];

    always_comb begin
        w_rr_off = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (w_req_rot[j]) begin
                w_rr_off = j[PW:0];
            end
        end
    end

    assign w_rr_idx    = wrap_add(r_ptr, w_rr_off);
    assign w_owner_oh  = ONE_HOT0 << r_owner;
    assign w_owner_req = |(bus.req & w_owner_oh);
    assign w_others    = |(bus.req & ~w_owner_oh);

    // The owner keeps the port while requesting, unless its burst budget is
    // spent and someone else is waiting; then plain round-robin takes over
    // (ptr already points just past the owner).
    assign w_hold = (r_state == ST_LOCKED) && w_owner_req &&
                    ((r_cnt < MAXB_W) || !w_others);
    assign w_win  = w_hold ? r_owner : w_rr_idx;
    assign w_gnt  = (rst || !(|bus.req)) ? '0 : (ONE_HOT0 << w_win);
    assign w_accept   = |w_gnt;
    assign w_win_we   = |(w_gnt & bus.req_we);
    assign w_win_lock = |(w_gnt & bus.req_lock);

    always_comb begin
        w_win_addr = '0;
        w_win_data = '0;
        w_win_bwe  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_win_addr = bus.req_addr[i*AW +: AW];
                w_win_data = bus.req_wdata[i*DW +: DW];
                w_win_bwe  = bus.req_bwe[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_cnt      <= '0;
            r_mem_ce   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_bwe  <= '0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_p0_vld   <= 1'b0;
            r_p0_id    <= '0;
            r_p1_vld   <= 1'b0;
            r_p1_id    <= '0;
        end else begin
            r_mem_ce <= w_accept;
            if (w_accept) begin
                r_mem_we   <= w_win_we;
                r_mem_bwe  <= w_win_bwe;
                r_mem_addr <= w_win_addr;
                r_mem_data <= w_win_data;
                r_ptr      <= wrap_add(w_win, ONE_P);
            end
            r_p0_vld <= w_accept && !w_win_we;
            r_p0_id  <= w_win;
            r_p1_vld <= r_p0_vld;
            r_p1_id  <= r_p0_id;

            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_win_lock) begin
                        r_state <= ST_LOCKED;
                        r_owner <= w_win;
                        r_cnt   <= 4'd1;
                    end
                end
                ST_LOCKED: begin
                    if (w_accept && (w_win == r_owner)) begin
                        if (w_win_lock) begin
                            // Saturate once the budget is spent.
                            if (r_cnt < MAXB_W) begin
                                r_cnt <= r_cnt + 4'd1;
                            end
                        end else begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                        end
                    end else if (w_accept && w_win_lock) begin
                        // Another requester won and asks for its own lock.
                        r_owner <= w_win;
                        r_cnt   <= 4'd1;
                    end else begin
                        // Owner dropped req (or lost on budget) without a
                        // new lock request from the winner.
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.gnt      = w_gnt;
    assign bus.rvalid   = r_p1_vld ? (ONE_HOT0 << r_p1_id) : '0;
    assign bus.rdata    = r_p1_vld ? bus.mem_q : '0;
    assign bus.mem_ce   = r_mem_ce;
    assign bus.mem_we   = r_mem_we;
    assign bus.mem_bwe  = r_mem_bwe;
    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_data = r_mem_data;
    assign bus.busy     = w_accept | r_mem_ce | r_p0_vld | r_p1_vld;
    assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_sram_port_arb.sv
module tb_sram_port_arb;
    localparam int NREQ = 4;
    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int MAXB = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [0:0] dbg_state;

    sram_port_arb_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    sram_port_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_BURST(MAXB)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- SRAM macro model ----------------
    logic [DW-1:0] sram [int];

    always @(posedge clk) begin
        if (bus.mem_ce) begin
            if (bus.mem_we) begin
                sram[int'(bus.mem_addr)] = ((sram.exists(int'(bus.mem_addr)) ?
                    sram[int'(bus.mem_addr)] : '0) & ~bus.mem_bwe) |
                    (bus.mem_data & bus.mem_bwe);
            end else begin
                bus.mem_q <= sram.exists(int'(bus.mem_addr)) ?
                             sram[int'(bus.mem_addr)] : '0;
            end
        end
    end

    // ---------------- reference model state ----------------
    logic [DW-1:0] shadow [int];
    int            m_ptr, m_owner, m_cnt;
    bit            m_locked;
    bit            m_ce, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data, m_bwe;
    bit            m_pw_vld;
    logic [AW-1:0] m_pw_addr;
    logic [DW-1:0] m_pw_data, m_pw_bwe;

    // expected read returns, in order
    logic [DW-1:0] exp_q[$];
    int            exp_due_q[$];
    int            exp_id_q[$];

    int            cyc;
    int            errors;
    int            checks;
    logic [NREQ-1:0] last_gnt;
    logic [NREQ-1:0] s_gnt, s_rvalid;
    logic [DW-1:0]   s_rdata;
    logic            s_ce;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] shadow_rd(input logic [AW-1:0] a);
        return shadow.exists(int'(a)) ? shadow[int'(a)] : '0;
    endfunction

    // Who must win this cycle, from the arbitration rules.
    function automatic int pick();
        int others;
        others = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req[i] && i != m_owner) others++;
        end
        if (m_locked && bus.req[m_owner] && (m_cnt < MAXB || others == 0)) begin
            return m_owner;
        end
        for (int k = 0; k < NREQ; k++) begin
            if (bus.req[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_owner = 0; m_cnt = 0; m_locked = 0;
        m_ce = 0; m_we = 0; m_addr = '0; m_data = '0; m_bwe = '0;
        m_pw_vld = 0;
        exp_q.delete(); exp_due_q.delete(); exp_id_q.delete();
        last_gnt = '0;
    endtask

    // One cycle: called at a falling edge with inputs already applied;
    // checks outputs, advances the model across the rising edge, and
    // returns at the next falling edge.
    task automatic cycle();
        int              w;
        logic [NREQ-1:0] eg, erv;
        bit              rd_due, we, lk;
        logic [AW-1:0]   a;
        #1;
        s_gnt = bus.gnt; s_rvalid = bus.rvalid; s_rdata = bus.rdata; s_ce = bus.mem_ce;
        if (rst) begin
            check("rst_gnt", 64'(bus.gnt), 0);
            check("rst_rvalid", 64'(bus.rvalid), 0);
            check("rst_rdata", 64'(bus.rdata), 0);
            check("rst_mem_ce", 64'(bus.mem_ce), 0);
            check("rst_mem_we", 64'(bus.mem_we), 0);
            check("rst_mem_bwe", 64'(bus.mem_bwe), 0);
            check("rst_mem_addr", 64'(bus.mem_addr), 0);
            check("rst_mem_data", 64'(bus.mem_data), 0);
            check("rst_busy", 64'(bus.busy), 0);
            check("rst_state", 64'(dbg_state), 0);
            model_reset();
        end else begin
            if (m_pw_vld) begin
                shadow[int'(m_pw_addr)] = (shadow_rd(m_pw_addr) & ~m_pw_bwe) |
                                          (m_pw_data & m_pw_bwe);
                m_pw_vld = 0;
            end
            w = pick();
            eg = '0;
            if (w >= 0) eg[w] = 1'b1;
            rd_due = (exp_due_q.size() > 0) && (exp_due_q[0] == cyc);
            erv = '0;
            if (rd_due) erv[exp_id_q[0]] = 1'b1;
            check("gnt", 64'(bus.gnt), 64'(eg));
            check("rvalid", 64'(bus.rvalid), 64'(erv));
            if (rd_due) check("rdata", 64'(bus.rdata), 64'(exp_q[0]));
            check("mem_ce", 64'(bus.mem_ce), 64'(m_ce));
            check("mem_we", 64'(bus.mem_we), 64'(m_we));
            check("mem_addr", 64'(bus.mem_addr), 64'(m_addr));
            check("mem_data", 64'(bus.mem_data), 64'(m_data));
            check("mem_bwe", 64'(bus.mem_bwe), 64'(m_bwe));
            check("busy", 64'(bus.busy), 64'((w >= 0) || m_ce || (exp_due_q.size() > 0)));
            check("lock_state", 64'(dbg_state), 64'(m_locked));
            if (rd_due) begin
                void'(exp_q.pop_front()); void'(exp_due_q.pop_front()); void'(exp_id_q.pop_front());
            end
            // state after the rising edge
            m_ce = (w >= 0);
            if (w >= 0) begin
                we = bus.req_we[w];
                lk = bus.req_lock[w];
                a  = bus.req_addr[w*AW +: AW];
                m_we = we; m_addr = a;
                m_data = bus.req_wdata[w*DW +: DW];
                m_bwe  = bus.req_bwe[w*DW +: DW];
                if (we) begin
                    m_pw_vld = 1; m_pw_addr = a; m_pw_data = m_data; m_pw_bwe = m_bwe;
                end else begin
                    exp_q.push_back(shadow_rd(a));
                    exp_due_q.push_back(cyc + 2);
                    exp_id_q.push_back(w);
                end
                if (m_locked && w == m_owner) begin
                    if (lk) m_cnt = (m_cnt < MAXB) ? m_cnt + 1 : MAXB;
                    else begin m_locked = 0; m_cnt = 0; end
                end else if (lk) begin
                    m_locked = 1; m_owner = w; m_cnt = 1;
                end else begin
                    m_locked = 0; m_cnt = 0;
                end
                m_ptr = (w + 1) % NREQ;
            end else begin
                m_locked = 0; m_cnt = 0;
            end
            last_gnt = eg;
        end
        cyc++;
        @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_cmd(input int i, input bit we, input bit lk,
                           input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW-1:0] be);
        bus.req_we[i]   = we;
        bus.req_lock[i] = lk;
        bus.req_addr[i*AW +: AW]  = a;
        bus.req_wdata[i*DW +: DW] = d;
        bus.req_bwe[i*DW +: DW]   = be;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic drive_random();
        logic [DW-1:0] be;
        for (int i = 0; i < NREQ; i++) begin
            if (!bus.req[i] || last_gnt[i]) begin
                bus.req[i] = ($urandom_range(0, 99) < 60);
                be = ($urandom_range(0, 1) == 1) ? {DW{1'b1}} : DW'($urandom());
                set_cmd(i, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                        AW'($urandom_range(0, 15)), DW'($urandom()), be);
            end
        end
    endtask

    // ---------------- stimulus ----------------
    logic [NREQ-1:0] g_log [0:15];
    logic [NREQ-1:0] rv_log [0:15];
    logic            ce_log [0:15];
    int              n_rv3;

    initial begin
        errors = 0; checks = 0; cyc = 0;
        bus.req = '0; bus.req_we = '0; bus.req_lock = '0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.req_bwe = '0;
        model_reset();
        rst = 1'b1;
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;

        // All four reading, no lock: plain rotation, data follows by 2.
        for (int i = 0; i < NREQ; i++) set_cmd(i, 0, 0, AW'(16'h0100 + i), '0, '1);
        for (int k = 0; k < 11; k++) begin
            bus.req = (k < 8) ? 4'b1111 : 4'b0000;
            cycle();
            g_log[k] = s_gnt; rv_log[k] = s_rvalid;
        end
        for (int k = 0; k < 8; k++) begin
            check("rr_gnt_seq", 64'(g_log[k]), 64'(1 << (k % 4)));
            check("rr_rvalid_seq", 64'(rv_log[k+2]), 64'(1 << (k % 4)));
        end

        // Write then read the same address on consecutive cycles.
        set_cmd(0, 1, 0, 16'h0010, 32'hDEADBEEF, 32'hFFFFFFFF);
        bus.req = 4'b0001;
        cycle();
        set_cmd(0, 0, 0, 16'h0010, '0, '1);
        cycle();
        bus.req = 4'b0000;
        cycle();
        cycle();
        check("wr_rd_rvalid", 64'(s_rvalid), 64'h1);
        check("wr_rd_rdata", 64'(s_rdata), 64'hDEADBEEF);

        // Partial bit-enable write.
        set_cmd(0, 1, 0, 16'h0020, 32'hDEADBEEF, 32'hFFFFFFFF);
        bus.req = 4'b0001;
        cycle();
        set_cmd(0, 1, 0, 16'h0020, 32'h12345678, 32'h0000FFFF);
        cycle();
        set_cmd(0, 0, 0, 16'h0020, '0, '1);
        cycle();
        bus.req = 4'b0000;
        cycle();
        cycle();
        check("partial_rvalid", 64'(s_rvalid), 64'h1);
        check("partial_rdata", 64'(s_rdata), 64'hDEAD5678);

        // Burst lock with a competing requester.
        do_reset();
        set_cmd(0, 0, 1, 16'h0030, '0, '1);
        set_cmd(2, 0, 0, 16'h0031, '0, '1);
        bus.req = 4'b0101;
        for (int k = 0; k < 6; k++) begin
            cycle();
            g_log[k] = s_gnt;
        end
        for (int k = 0; k < 4; k++) check("burst_owner", 64'(g_log[k]), 64'h1);
        check("burst_handoff", 64'(g_log[4]), 64'h4);
        check("burst_after_ptr", 64'(g_log[5]), 64'h1);

        // Burst lock with nobody else waiting: the owner keeps going.
        do_reset();
        bus.req = 4'b0001;
        for (int k = 0; k < 7; k++) begin
            cycle();
            g_log[k] = s_gnt;
        end
        for (int k = 0; k < 7; k++) check("burst_alone", 64'(g_log[k]), 64'h1);
        bus.req = 4'b0000;
        set_cmd(0, 0, 0, 16'h0030, '0, '1);
        cycle();
        cycle();
        cycle();

        // Reset lands between a read accept and its data slot.
        do_reset();
        set_cmd(1, 0, 0, 16'h0040, '0, '1);
        bus.req = 4'b0010;
        cycle();
        bus.req = 4'b0000;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        check("rst_drop_rvalid", 64'(s_rvalid), 0);
        bus.req = 4'b1111;
        cycle();
        check("post_rst_first_gnt", 64'(s_gnt), 64'h1);
        bus.req = 4'b0000;
        cycle();
        cycle();

        // Lone requester 3 streaming reads.
        do_reset();
        set_cmd(3, 0, 0, 16'h0050, '0, '1);
        n_rv3 = 0;
        for (int k = 0; k < 13; k++) begin
            bus.req = (k < 10) ? 4'b1000 : 4'b0000;
            cycle();
            g_log[k] = s_gnt; ce_log[k] = s_ce;
            if (s_rvalid[3]) n_rv3++;
        end
        for (int k = 0; k < 10; k++) check("solo_gnt", 64'(g_log[k]), 64'h8);
        for (int k = 1; k < 11; k++) check("solo_mem_ce", 64'(ce_log[k]), 64'h1);
        check("solo_rvalid_count", 64'(n_rv3), 64'd10);

        // Randomized traffic, with an occasional reset.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 299) == 0);
            drive_random();
            cycle();
        end
        rst = 1'b0;
        bus.req = '0;
        for (int k = 0; k < 4; k++) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
